// File: rtl/fetch_stage_if.sv
// Bundles the fetch-stage traffic: instruction-memory address/data,
// decode stall, EX redirect, and the IF/ID register outputs.
interface fetch_stage_if;
  logic [63:0] instAddress;
  logic [31:0] instruction;
  logic        stall;
  logic        redirectValid;
  logic [63:0] redirectTarget;
  logic [63:0] ifidPc;
  logic [31:0] ifidInstruction;
  logic        ifidValid;
  logic        fetchDone;
  logic        misalignError;

  // The fetch stage itself.
  modport master (
    output instAddress, ifidPc, ifidInstruction, ifidValid, fetchDone, misalignError,
    input  instruction, stall, redirectValid, redirectTarget
  );

  // Memory, decoder and EX stage seen from the outside.
  modport slave (
    input  instAddress, ifidPc, ifidInstruction, ifidValid, fetchDone, misalignError,
    output instruction, stall, redirectValid, redirectTarget
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, and
// captures the returned word into the IF/ID register. A small RUN/DONE/ERROR
// FSM handles running off the end of memory and misaligned redirect targets.
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int unsigned MEM_BYTES = 124,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DONE  = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 4);

  state_t      state_q;
  logic [63:0] pc_q;
  logic [63:0] ifid_pc_q;
  logic [31:0] ifid_instr_q;
  logic        ifid_valid_q;
  logic        fetch_done_q;
  logic        misalign_q;

  logic [63:0] pc_inc_d;
  logic        pc_in_range;
  logic        target_aligned;

  // Sequential PC increment wraps naturally modulo 2^64.
  assign pc_inc_d       = pc_q + 64'd4;
  assign pc_in_range    = (pc_q <= LAST_ADDR);
  assign target_aligned = (bus.redirectTarget[1:0] == 2'b00);

  // Single FSM: PC, IF/ID register and status flags all update here.
  // NOTE: every register in this block uses <= so all of them sample the
  // pre-edge values; a blocking = here would let later lines see new state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: async reset puts every flop in a known state immediately,
      // without waiting for a clock edge.
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 64'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      fetch_done_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.redirectValid) begin
            // Redirect wins over stall: flush the wrong-path instruction.
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            if (target_aligned) begin
              pc_q <= bus.redirectTarget;
            end else begin
              state_q    <= ERROR;
              misalign_q <= 1'b1;
            end
          end else if (!bus.stall) begin
            if (pc_in_range) begin
              ifid_pc_q    <= pc_q;
              ifid_instr_q <= bus.instruction;
              ifid_valid_q <= 1'b1;
              pc_q         <= pc_inc_d;
            end else begin
              state_q      <= DONE;
              fetch_done_q <= 1'b1;
              ifid_valid_q <= 1'b0;
              ifid_instr_q <= NOP_INSTR;
            end
          end
        end

        DONE: begin
          // Stall is irrelevant here; only a late redirect can restart fetch.
          if (bus.redirectValid) begin
            fetch_done_q <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            if (target_aligned) begin
              state_q <= RUN;
              pc_q    <= bus.redirectTarget;
            end else begin
              state_q    <= ERROR;
              misalign_q <= 1'b1;
            end
          end
        end

        ERROR: begin
          // Sticky until reset; redirects are ignored.
        end

        default: begin
          state_q      <= ERROR;
          misalign_q   <= 1'b1;
          fetch_done_q <= 1'b0;
          ifid_valid_q <= 1'b0;
          ifid_instr_q <= NOP_INSTR;
        end
      endcase
    end
  end

  assign bus.instAddress     = pc_q;
  assign bus.ifidPc          = ifid_pc_q;
  assign bus.ifidInstruction = ifid_instr_q;
  assign bus.ifidValid       = ifid_valid_q;
  assign bus.fetchDone       = fetch_done_q;
  assign bus.misalignError   = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the stimulus process drives inputs and
// pushes the model's expected post-edge outputs; a monitor pops and compares
// them one time unit after each rising edge.
module tb_fetch_stage;

  localparam int unsigned MEM_BYTES = 124;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [63:0] LAST      = 64'(MEM_BYTES - 4);

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC (64'd0),
    .MEM_BYTES(MEM_BYTES),
    .NOP_INSTR(NOP)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Instruction memory model: combinational read.
  logic [31:0] mem [0:30];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a <= LAST) return mem[a[6:2]];
    return 32'hBADC_0DE5;
  endfunction

  always_comb bus.instruction = mem_word(bus.instAddress);

  typedef struct {
    logic [63:0] addr;
    logic [63:0] ifpc;
    logic [31:0] ifinst;
    logic        valid;
    logic        done;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: the fetch rules stated directly.
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_ifinst;
  logic        m_valid, m_done, m_err;

  task automatic model_reset();
    m_pc = 64'd0; m_ifpc = 64'd0; m_ifinst = NOP;
    m_valid = 1'b0; m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic rv, input logic [63:0] tgt);
    if (m_err) return;                       // frozen until reset
    if (rv) begin
      m_valid = 1'b0; m_ifinst = NOP; m_done = 1'b0;
      if (tgt % 4 != 0) m_err = 1'b1;
      else m_pc = tgt;
    end else if (m_done || s) begin
      // hold everything
    end else if (m_pc <= LAST) begin
      m_ifpc = m_pc; m_ifinst = mem_word(m_pc); m_valid = 1'b1;
      m_pc = m_pc + 64'd4;
    end else begin
      m_done = 1'b1; m_valid = 1'b0; m_ifinst = NOP;
    end
  endtask

  // Called at a falling edge: drive inputs, predict, then move to the next falling edge.
  task automatic step(input logic s, input logic rv, input logic [63:0] tgt);
    exp_t e;
    bus.stall = s; bus.redirectValid = rv; bus.redirectTarget = tgt;
    model_step(s, rv, tgt);
    e.addr = m_pc; e.ifpc = m_ifpc; e.ifinst = m_ifinst;
    e.valid = m_valid; e.done = m_done; e.err = m_err;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_instAddress"},     bus.instAddress,     64'd0);
    check({tag, "_ifidPc"},          bus.ifidPc,          64'd0);
    check({tag, "_ifidInstruction"}, bus.ifidInstruction, NOP);
    check({tag, "_ifidValid"},       bus.ifidValid,       1'b0);
    check({tag, "_fetchDone"},       bus.fetchDone,       1'b0);
    check({tag, "_misalignError"},   bus.misalignError,   1'b0);
  endtask

  // Asynchronous reset mid-cycle (called at a falling edge, no edge before the check).
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_reset");
    bus.stall = 1'b0; bus.redirectValid = 1'b0; bus.redirectTarget = 64'd0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: compare every presented output set against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("instAddress",     bus.instAddress,     e.addr);
        check("ifidPc",          bus.ifidPc,          e.ifpc);
        check("ifidInstruction", bus.ifidInstruction, e.ifinst);
        check("ifidValid",       bus.ifidValid,       e.valid);
        check("fetchDone",       bus.fetchDone,       e.done);
        check("misalignError",   bus.misalignError,   e.err);
      end
    end
  end

  // Stimulus.
  initial begin
    logic        s, rv;
    logic [63:0] tgt;
    int unsigned r;

    for (int i = 0; i <= 30; i++) mem[i] = $urandom;
    mem[0]  = 32'h0040_0293;
    mem[1]  = 32'h0000_0313;
    mem[2]  = 32'h00A0_0693;
    mem[10] = 32'hFE00_04E3;   // 0x28
    mem[11] = 32'h0010_0313;   // 0x2C
    mem[30] = 32'hFA00_0CE3;   // 120

    bus.stall = 1'b0; bus.redirectValid = 1'b0; bus.redirectTarget = 64'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_values("power_on_reset");
    reset_n = 1'b1;

    // Straight-line fetch from 0, then a two-cycle stall at pc=8.
    step(0, 0, 0); step(0, 0, 0);
    step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 0);
    // Redirect with simultaneous stall, then fetch at the target.
    step(1, 1, 64'h28);
    step(0, 0, 0);
    // Run to the last word and past the end, then restart via redirect.
    step(0, 1, 64'd120);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 64'h2C);
    step(0, 0, 0);
    // Misaligned target traps; later redirects and fetches are ignored.
    step(0, 1, 64'h2A);
    step(0, 1, 64'h0);
    step(0, 0, 0);
    do_reset();
    // Park pc at 0x3C and reset asynchronously.
    step(0, 1, 64'h3C);
    step(1, 0, 0);
    do_reset();

    // Randomised traffic with periodic resets.
    for (int n = 0; n < 2000; n++) begin
      s  = ($urandom_range(0, 99) < 30);
      rv = ($urandom_range(0, 99) < 15);
      r  = $urandom_range(0, 99);
      if (r < 70)      tgt = 64'($urandom_range(0, 30)) * 64'd4;
      else if (r < 82) tgt = 64'($urandom_range(31, 400)) * 64'd4;
      else if (r < 92) tgt = 64'hFFFF_FFFF_FFFF_FFFC;
      else             tgt = 64'($urandom_range(0, 30)) * 64'd4 + 64'($urandom_range(1, 3));
      step(s, rv, tgt);
      if (n % 250 == 249) do_reset();
    end

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
